// File: rtl/cpu64_l2_dir_ctrl_pkg.sv
// cpu64_l2_pkg: op encodings, FSM states and directory entry layout for the L2 directory controller
package cpu64_l2_pkg;
    localparam int L2_CORES = 4;
    localparam int L2_OID_W = $clog2(L2_CORES);
    typedef enum logic [2:0] {
        DIR_GET_S      = 3'd0,
        DIR_GET_M      = 3'd1,
        DIR_PUT_S      = 3'd2,
        DIR_PUT_M      = 3'd3,
        DIR_MARK_DIRTY = 3'd4,
        DIR_EVICT      = 3'd5
    } dir_op_e;
    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, UPDATE, RESP} dir_state_e;
    typedef struct packed {
        logic                valid;
        logic [L2_CORES-1:0] sharers;
        logic                owner_valid;
        logic [L2_OID_W-1:0] owner_id;
        logic                dirty;
    } dir_entry_t;
endpackage

// File: rtl/cpu64_l2_dir_ctrl_if.sv
// cpu64_l2_dir_ctrl_if: request/response handshake bundle between the coherence front end and the directory controller
interface cpu64_l2_dir_ctrl_if import cpu64_l2_pkg::*; #(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = L2_CORES
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [2:0]               req_op_i;
    logic [$clog2(SETS)-1:0]  req_set_i;
    logic [$clog2(WAYS)-1:0]  req_way_i;
    logic [$clog2(CORES)-1:0] req_core_i;
    logic                     resp_valid_o;
    logic                     resp_ready_i;
    logic [CORES-1:0]         resp_probe_o;
    logic                     resp_wb_o;
    logic                     resp_err_o;
    modport slave (
        input  req_valid_i, req_op_i, req_set_i, req_way_i, req_core_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_probe_o, resp_wb_o, resp_err_o
    );
    modport master (
        output req_valid_i, req_op_i, req_set_i, req_way_i, req_core_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_probe_o, resp_wb_o, resp_err_o
    );
endinterface

// File: rtl/cpu64_l2_dir_ctrl_next.sv
// cpu64_l2_dir_next: combinational directory entry transition with probe/writeback/error outcome
module cpu64_l2_dir_next import cpu64_l2_pkg::*; (
    input  logic [2:0]          op_i,
    input  logic [L2_OID_W-1:0] core_i,
    input  dir_entry_t          old_i,
    output dir_entry_t          new_o,
    output logic [L2_CORES-1:0] probe_o,
    output logic                wb_o,
    output logic                err_o
);
    logic [L2_CORES-1:0] c_bit;
    logic [L2_CORES-1:0] own_bit;
    logic                own;
    assign c_bit   = L2_CORES'(1) << core_i;
    assign own_bit = old_i.owner_valid ? (L2_CORES'(1) << old_i.owner_id) : '0;
    assign own     = old_i.owner_valid && old_i.owner_id == core_i;
    // error paths leave the entry, probe and wb at their defaults
    always_comb begin
        new_o   = old_i;
        probe_o = '0;
        wb_o    = 1'b0;
        err_o   = 1'b0;
        case (op_i)
            DIR_GET_S: begin
                new_o.valid = 1'b1;
                if (old_i.owner_valid && !own) begin
                    probe_o           = own_bit;
                    wb_o              = old_i.dirty;
                    new_o.sharers     = own_bit | c_bit;
                    new_o.owner_valid = 1'b0;
                    new_o.owner_id    = '0;
                    new_o.dirty       = 1'b0;
                end else if (!own) new_o.sharers = old_i.sharers | c_bit;
            end
            DIR_GET_M: begin
                probe_o = (old_i.sharers | own_bit) & ~c_bit;
                wb_o    = old_i.dirty && !own;
                new_o   = '{valid: 1'b1, sharers: '0, owner_valid: 1'b1, owner_id: core_i, dirty: own && old_i.dirty};
            end
            DIR_PUT_S: if (old_i.sharers[core_i]) new_o.sharers[core_i] = 1'b0; else err_o = 1'b1;
            DIR_PUT_M: begin
                if (own) begin
                    wb_o              = old_i.dirty;
                    new_o.owner_valid = 1'b0;
                    new_o.owner_id    = '0;
                    new_o.dirty       = 1'b0;
                end else err_o = 1'b1;
            end
            DIR_MARK_DIRTY: if (own) new_o.dirty = 1'b1; else err_o = 1'b1;
            DIR_EVICT: begin
                probe_o = old_i.valid ? (old_i.sharers | own_bit) : '0;
                wb_o    = old_i.valid && old_i.dirty;
                new_o   = '0;
            end
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/cpu64_l2_dir_ctrl.sv
// cpu64_l2_dir_ctrl: L2 directory update engine with post-reset invalidation sweep
module cpu64_l2_dir_ctrl import cpu64_l2_pkg::*; #(
    parameter  int SETS       = 256,
    parameter  int WAYS       = 16,
    parameter  int CORES      = L2_CORES,
    localparam int OWNER_ID_W = $clog2(CORES),
    localparam int SW         = $clog2(SETS),
    localparam int WW         = $clog2(WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    cpu64_l2_dir_ctrl_if.slave         bus,
    output logic                       init_done_o,
    output logic [SW-1:0]              dir_rd_set_o,
    input  logic [WAYS-1:0]            dir_rd_valid_i,
    input  logic [WAYS*CORES-1:0]      dir_rd_sharers_i,
    input  logic [WAYS-1:0]            dir_rd_owner_valid_i,
    input  logic [WAYS*OWNER_ID_W-1:0] dir_rd_owner_id_i,
    input  logic [WAYS-1:0]            dir_rd_dirty_i,
    output logic                       dir_we_o,
    output logic [SW-1:0]              dir_wr_set_o,
    output logic [WW-1:0]              dir_wr_way_o,
    output logic                       dir_wr_valid_o,
    output logic [CORES-1:0]           dir_wr_sharers_o,
    output logic                       dir_wr_owner_valid_o,
    output logic [OWNER_ID_W-1:0]      dir_wr_owner_id_o,
    output logic                       dir_wr_dirty_o
);
    dir_state_e              state_q, state_d;
    logic [SW+WW-1:0]        cnt_q;
    logic [2:0]              op_q;
    logic [SW-1:0]           set_q;
    logic [WW-1:0]           way_q;
    logic [OWNER_ID_W-1:0]   core_q;
    dir_entry_t              ent_q, sel, nxt, wr;
    logic [CORES-1:0]        probe, probe_q;
    logic                    wb, wb_q, err, err_q, done_q, init;
    assign init = state_q == INIT;
    assign sel  = '{valid:       dir_rd_valid_i[way_q],
                    sharers:     dir_rd_sharers_i[way_q*CORES +: CORES],
                    owner_valid: dir_rd_owner_valid_i[way_q],
                    owner_id:    dir_rd_owner_id_i[way_q*OWNER_ID_W +: OWNER_ID_W],
                    dirty:       dir_rd_dirty_i[way_q]};
    cpu64_l2_dir_next u_next (
        .op_i    (op_q),
        .core_i  (core_q),
        .old_i   (ent_q),
        .new_o   (nxt),
        .probe_o (probe),
        .wb_o    (wb),
        .err_o   (err)
    );
    // sweep until the last set/way, then serve one request at a time
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = &cnt_q ? IDLE : INIT;
            IDLE:    state_d = bus.req_valid_i ? LOOKUP : IDLE;
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = RESP;
            RESP:    state_d = bus.resp_ready_i ? IDLE : RESP;
            default: state_d = INIT;
        endcase
    end
    // state, sweep counter, captured request, looked-up entry and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            op_q    <= '0;
            set_q   <= '0;
            way_q   <= '0;
            core_q  <= '0;
            ent_q   <= '0;
            probe_q <= '0;
            wb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (init) cnt_q <= cnt_q + 1'b1;
            if (init && &cnt_q) done_q <= 1'b1;
            if (state_q == IDLE && bus.req_valid_i) begin
                op_q   <= bus.req_op_i;
                set_q  <= bus.req_set_i;
                way_q  <= bus.req_way_i;
                core_q <= bus.req_core_i;
            end
            if (state_q == LOOKUP) ent_q <= sel;
            if (state_q == UPDATE) begin
                probe_q <= probe;
                wb_q    <= wb;
                err_q   <= err;
            end
        end
    end
    assign bus.req_ready_o  = !rst && state_q == IDLE;
    assign bus.resp_valid_o = !rst && state_q == RESP;
    assign bus.resp_probe_o = probe_q;
    assign bus.resp_wb_o    = wb_q;
    assign bus.resp_err_o   = err_q;
    assign init_done_o      = done_q;
    assign dir_rd_set_o     = set_q;
    assign dir_we_o         = !rst && (init || (state_q == UPDATE && !err));
    assign wr               = init ? '0 : nxt;
    assign dir_wr_set_o     = init ? cnt_q[SW+WW-1:WW] : set_q;
    assign dir_wr_way_o     = init ? cnt_q[WW-1:0] : way_q;
    assign {dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o} = wr;
endmodule

// File: tb/tb_cpu64_l2_dir_ctrl.sv
// tb_cpu64_l2_dir_ctrl: directed self-checking bench with a small directory array model
module tb_cpu64_l2_dir_ctrl;
    import cpu64_l2_pkg::*;
    localparam int SETS = 8, WAYS = 4, CORES = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    cpu64_l2_dir_ctrl_if #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) bus();
    logic        init_done, we, wr_v, wr_ov, wr_d;
    logic [2:0]  rd_set, wr_set;
    logic [1:0]  wr_way, wr_oid;
    logic [3:0]  rd_valid, rd_ov, rd_d, wr_sh;
    logic [15:0] rd_sh;
    logic [7:0]  rd_oid;
    logic [3:0]  m_valid [SETS];
    logic [15:0] m_sh    [SETS];
    logic [3:0]  m_ov    [SETS];
    logic [7:0]  m_oid   [SETS];
    logic [3:0]  m_d     [SETS];
    logic        poison = 1'b0;
    int          we_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    cpu64_l2_dir_ctrl #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .init_done_o          (init_done),
        .dir_rd_set_o         (rd_set),
        .dir_rd_valid_i       (rd_valid),
        .dir_rd_sharers_i     (rd_sh),
        .dir_rd_owner_valid_i (rd_ov),
        .dir_rd_owner_id_i    (rd_oid),
        .dir_rd_dirty_i       (rd_d),
        .dir_we_o             (we),
        .dir_wr_set_o         (wr_set),
        .dir_wr_way_o         (wr_way),
        .dir_wr_valid_o       (wr_v),
        .dir_wr_sharers_o     (wr_sh),
        .dir_wr_owner_valid_o (wr_ov),
        .dir_wr_owner_id_o    (wr_oid),
        .dir_wr_dirty_o       (wr_d)
    );
    assign rd_valid = m_valid[rd_set];
    assign rd_sh    = m_sh[rd_set];
    assign rd_ov    = m_ov[rd_set];
    assign rd_oid   = m_oid[rd_set];
    assign rd_d     = m_d[rd_set];
    // directory array: poison fills with ones, otherwise accept DUT writes
    always @(posedge clk) begin
        if (we) we_cnt <= we_cnt + 1;
        if (poison) begin
            for (int s = 0; s < SETS; s++) begin
                m_valid[s] <= '1;
                m_sh[s]    <= '1;
                m_ov[s]    <= '1;
                m_oid[s]   <= '1;
                m_d[s]     <= '1;
            end
        end else if (we) begin
            m_valid[wr_set][wr_way]       <= wr_v;
            m_sh[wr_set][wr_way*4 +: 4]   <= wr_sh;
            m_ov[wr_set][wr_way]          <= wr_ov;
            m_oid[wr_set][wr_way*2 +: 2]  <= wr_oid;
            m_d[wr_set][wr_way]           <= wr_d;
        end
    end
    function automatic logic [8:0] ent(int s, int w);
        return {m_valid[s][w], m_sh[s][w*4 +: 4], m_ov[s][w], m_oid[s][w*2 +: 2], m_d[s][w]};
    endfunction
    function automatic bit all_zero();
        for (int s = 0; s < SETS; s++)
            if ((m_valid[s] | m_ov[s] | m_d[s]) !== 4'b0 || m_sh[s] !== 16'b0 || m_oid[s] !== 8'b0) return 1'b0;
        return 1'b1;
    endfunction
    task automatic send(input logic [2:0] op, input logic [2:0] s, input logic [1:0] w, input logic [1:0] c,
                        output int lat);
        int n;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_set_i   = s;
        bus.req_way_i   = w;
        bus.req_core_i  = c;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready_o) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout op=%0d got ready=0 expected 1", op);
            bus.req_valid_i = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.resp_valid_o) begin
            checks++; errors++;
            $display("FAIL resp_valid_timeout op=%0d got valid=0 expected 1", op);
        end
    endtask
    task automatic ack();
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready_i = 1'b0;
    endtask
    task automatic test_reset();
        int w0;
        rst = 1'b1;
        poison = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        poison = 1'b0;
        checks++;
        if ({bus.req_ready_o, bus.resp_valid_o, init_done, we, bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {bus.req_ready_o, bus.resp_valid_o, init_done, we});
        end
        rst = 1'b0;
        w0 = we_cnt;
        #1;
        checks++;
        if ({we, wr_set, wr_way, wr_v, wr_sh, wr_ov, wr_oid, wr_d} !== {1'b1, 14'b0}) begin
            errors++;
            $display("FAIL sweep_first got we=%b set=%0d way=%0d expected we=1 set=0 way=0", we, wr_set, wr_way);
        end
        repeat (31) @(posedge clk);
        #1;
        checks++;
        if ({init_done, we, bus.req_ready_o} !== 3'b010) begin
            errors++;
            $display("FAIL sweep_cycle32 got done/we/ready=%b expected 010", {init_done, we, bus.req_ready_o});
        end
        @(posedge clk); #1;
        checks++;
        if ({init_done, we, bus.req_ready_o} !== 3'b101 || we_cnt - w0 != 32) begin
            errors++;
            $display("FAIL sweep_done got done/we/ready=%b writes=%0d expected 101 writes=32",
                     {init_done, we, bus.req_ready_o}, we_cnt - w0);
        end
        checks++;
        if (!all_zero()) begin
            errors++;
            $display("FAIL sweep_zero got nonzero directory expected all zero");
        end
    endtask
    task automatic test_restart();
        int w0;
        rst = 1'b1;
        poison = 1'b1;
        @(posedge clk); #1;
        poison = 1'b0;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = we_cnt;
        #1;
        checks++;
        if ({we, wr_set, wr_way, init_done} !== {1'b1, 3'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_origin got we=%b set=%0d way=%0d done=%b expected 1 0 0 0", we, wr_set, wr_way, init_done);
        end
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if (init_done !== 1'b1 || we_cnt - w0 != 32 || !all_zero()) begin
            errors++;
            $display("FAIL restart_sweep got done=%b writes=%0d expected done=1 writes=32 all zero", init_done, we_cnt - w0);
        end
    endtask
    task automatic test_get_s();
        int lat, w0;
        w0 = we_cnt;
        send(DIR_GET_S, 3'd3, 2'd2, 2'd1, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL latency got %0d expected 3", lat);
        end
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0000_0_0 || we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL gets1_resp got %b writes=%0d expected 000000 writes=1",
                     {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o}, we_cnt - w0);
        end
        ack();
        checks++;
        if ({bus.req_ready_o, bus.resp_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL ready_after_ack got %b expected 10", {bus.req_ready_o, bus.resp_valid_o});
        end
        checks++;
        if (ent(3, 2) !== 9'b1_0010_0_00_0) begin
            errors++;
            $display("FAIL gets1_entry got %b expected 100100000", ent(3, 2));
        end
        send(DIR_GET_S, 3'd3, 2'd2, 2'd2, lat);
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL gets2_resp got %b expected 000000", {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o});
        end
        ack();
        checks++;
        if (ent(3, 2) !== 9'b1_0110_0_00_0) begin
            errors++;
            $display("FAIL gets2_entry got %b expected 101100000", ent(3, 2));
        end
    endtask
    task automatic test_get_m();
        int lat;
        send(DIR_GET_M, 3'd3, 2'd2, 2'd3, lat);
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0110_0_0) begin
            errors++;
            $display("FAIL getm_resp got %b expected 011000", {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o});
        end
        ack();
        checks++;
        if (ent(3, 2) !== 9'b1_0000_1_11_0) begin
            errors++;
            $display("FAIL getm_entry got %b expected 100001110", ent(3, 2));
        end
    endtask
    task automatic test_dirty_share();
        int lat;
        send(DIR_MARK_DIRTY, 3'd3, 2'd2, 2'd3, lat);
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL mark_resp got %b expected 000000", {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o});
        end
        ack();
        checks++;
        if (ent(3, 2) !== 9'b1_0000_1_11_1) begin
            errors++;
            $display("FAIL mark_entry got %b expected 100001111", ent(3, 2));
        end
        send(DIR_GET_S, 3'd3, 2'd2, 2'd0, lat);
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b1000_1_0) begin
            errors++;
            $display("FAIL downgrade_resp got %b expected 100010", {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o});
        end
        ack();
        checks++;
        if (ent(3, 2) !== 9'b1_1001_0_00_0) begin
            errors++;
            $display("FAIL downgrade_entry got %b expected 110010000", ent(3, 2));
        end
    endtask
    task automatic test_errors();
        int lat, w0;
        logic [2:0] ops [3] = '{DIR_PUT_M, 3'd7, DIR_PUT_S};
        logic [1:0] cs  [3] = '{2'd2, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            w0 = we_cnt;
            send(ops[i], 3'd3, 2'd2, cs[i], lat);
            checks++;
            if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0000_0_1 || we_cnt != w0) begin
                errors++;
                $display("FAIL err_op%0d got %b writes=%0d expected 000001 writes=0",
                         ops[i], {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o}, we_cnt - w0);
            end
            ack();
            checks++;
            if (ent(3, 2) !== 9'b1_1001_0_00_0) begin
                errors++;
                $display("FAIL err_entry_op%0d got %b expected 110010000", ops[i], ent(3, 2));
            end
        end
        send(DIR_PUT_S, 3'd3, 2'd2, 2'd0, lat);
        checks++;
        if (bus.resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL puts_ok got err=%b expected 0", bus.resp_err_o);
        end
        ack();
        checks++;
        if (ent(3, 2) !== 9'b1_1000_0_00_0) begin
            errors++;
            $display("FAIL puts_entry got %b expected 110000000", ent(3, 2));
        end
    endtask
    task automatic test_owner();
        int lat;
        send(DIR_GET_M, 3'd4, 2'd3, 2'd2, lat);
        ack();
        send(DIR_GET_S, 3'd4, 2'd3, 2'd2, lat);
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL owner_gets_resp got %b expected 000000", {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o});
        end
        ack();
        checks++;
        if (ent(4, 3) !== 9'b1_0000_1_10_0) begin
            errors++;
            $display("FAIL owner_gets_entry got %b expected 100001100", ent(4, 3));
        end
        send(DIR_PUT_M, 3'd4, 2'd3, 2'd2, lat);
        ack();
        checks++;
        if (ent(4, 3) !== 9'b1_0000_0_00_0) begin
            errors++;
            $display("FAIL putm_entry got %b expected 100000000", ent(4, 3));
        end
    endtask
    task automatic test_stall_evict();
        int lat, w0;
        send(DIR_GET_M, 3'd5, 2'd1, 2'd1, lat);
        ack();
        send(DIR_MARK_DIRTY, 3'd5, 2'd1, 2'd1, lat);
        ack();
        send(DIR_EVICT, 3'd5, 2'd1, 2'd0, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o, bus.resp_valid_o, bus.req_ready_o} !== 8'b0010_1_0_1_0) begin
                errors++;
                $display("FAIL stall_cycle%0d got %b expected 00101010", i,
                         {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o, bus.resp_valid_o, bus.req_ready_o});
            end
            @(posedge clk); #1;
        end
        ack();
        checks++;
        if (ent(5, 1) !== 9'b0) begin
            errors++;
            $display("FAIL evict_entry got %b expected 000000000", ent(5, 1));
        end
        w0 = we_cnt;
        send(DIR_EVICT, 3'd6, 2'd0, 2'd3, lat);
        checks++;
        if ({bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o} !== 6'b0000_0_0 || we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL evict_invalid got %b writes=%0d expected 000000 writes=1",
                     {bus.resp_probe_o, bus.resp_wb_o, bus.resp_err_o}, we_cnt - w0);
        end
        ack();
    endtask
    task automatic test_back_to_back();
        int lat;
        send(DIR_GET_S, 3'd7, 2'd0, 2'd0, lat);
        ack();
        send(DIR_GET_S, 3'd7, 2'd0, 2'd3, lat);
        ack();
        checks++;
        if (ent(7, 0) !== 9'b1_1001_0_00_0) begin
            errors++;
            $display("FAIL b2b_entry got %b expected 110010000", ent(7, 0));
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = '0;
        bus.req_set_i    = '0;
        bus.req_way_i    = '0;
        bus.req_core_i   = '0;
        bus.resp_ready_i = 1'b0;
        test_reset();
        test_restart();
        test_get_s();
        test_get_m();
        test_dirty_share();
        test_errors();
        test_owner();
        test_stall_evict();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu64_l2_dir_ctrl.md
Name: cpu64_l2_dir_ctrl

Overview:
Directory update engine and sole driver of the L2 directory's read and write ports. It accepts one coherence request at a time (core, set, way, op) and reads the set. It computes the next directory entry plus the probe and writeback obligations, writes the entry back, and returns a response. After reset it sweeps every set/way to the invalid state before accepting requests.

Parameters:
SETS, 256, number of directory sets
WAYS, 16, ways per set
CORES, 4, number of L1 clients; OWNER_ID_W = $clog2(CORES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  3  op encoding (see Behaviour)
req_set_i  in  $clog2(SETS)  target set
req_way_i  in  $clog2(WAYS)  target way (tag match done upstream)
req_core_i  in  OWNER_ID_W  requesting core
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed
resp_probe_o  out  CORES  cores that must be probed/invalidated
resp_wb_o  out  1  dirty data must be written back to L2
resp_err_o  out  1  illegal op or protocol violation; entry unchanged
init_done_o  out  1  init sweep complete
dir_rd_set_o  out  $clog2(SETS)  directory read address (combinational read)
dir_rd_valid_i  in  WAYS  per-way valid
dir_rd_sharers_i  in  WAYS*CORES  per-way sharer vectors
dir_rd_owner_valid_i  in  WAYS  per-way owner valid
dir_rd_owner_id_i  in  WAYS*OWNER_ID_W  per-way owner id
dir_rd_dirty_i  in  WAYS  per-way dirty
dir_we_o  out  1  directory write enable
dir_wr_set_o  out  $clog2(SETS)  write set
dir_wr_way_o  out  $clog2(WAYS)  write way
dir_wr_valid_o / dir_wr_sharers_o / dir_wr_owner_valid_o / dir_wr_owner_id_o / dir_wr_dirty_o  out  1/CORES/1/OWNER_ID_W/1  write entry fields

Behaviour:
- Reset values:
  - req_ready_o=0, resp_*=0, init_done_o=0, dir_we_o=0, all counters 0.
  - State goes to INIT.
  - rst asserted in any state restarts INIT; an in-flight request/response is dropped.
- INIT:
  - One directory write per cycle, all fields 0, iterating way (inner) then set (outer).
  - Takes exactly SETS*WAYS cycles.
  - On the write to (SETS-1, WAYS-1): next state is IDLE and init_done_o=1, which stays 1 until reset.
- IDLE:
  - req_ready_o=1.
  - On handshake, register op/set/way/core and go to LOOKUP.
- LOOKUP (1 cycle):
  - dir_rd_set_o = registered set.
  - Capture the selected way's fields into an entry register.
  - Go to UPDATE.
- UPDATE (1 cycle):
  - Drive dir_we_o=1 with the next-state entry, unless err=1, in which case dir_we_o=0.
  - Load the response registers and go to RESP.
- RESP:
  - resp_valid_o=1, fields stable until resp_ready_i.
  - On handshake go to IDLE; req_ready_o returns the next cycle.
- Timing: minimum accept-to-resp_valid is 3 cycles; throughput is at most one request per 4 cycles.
- Ops (c = requesting core, own = owner_valid & owner_id==c):
  - 0 GET_S:
    - If owner_valid&!own: probe=owner bit, wb=dirty; new sharers={owner,c}, owner_valid=0, dirty=0.
    - If own: entry unchanged, probe=0.
    - Else: sharers|=c.
    - valid=1 in all cases.
  - 1 GET_M:
    - probe=(sharers|owner bit)&~c, wb=dirty&!own.
    - New owner_valid=1, owner_id=c, sharers=0, valid=1.
    - dirty=own?dirty:0.
  - 2 PUT_S: requires sharers[c]=1, else err. Clears sharers[c]; valid unchanged.
  - 3 PUT_M: requires own, else err. wb=dirty; new owner_valid=0, owner_id=0, dirty=0.
  - 4 MARK_DIRTY: requires own, else err. Sets dirty=1.
  - 5 EVICT:
    - probe=sharers|owner bit (owner bit only if owner_valid), wb=dirty.
    - Writes all-zero entry.
    - EVICT of an invalid entry: probe=0, wb=0, write still issued.
  - 6,7: err=1, no write.
- Field rules:
  - When owner_valid=0, written owner_id=0.
  - Written entries always satisfy dirty→owner_valid and owner_valid→sharers==0.
  - err responses have probe=0, wb=0.
- Back-to-back requests to the same set are serialized; no forwarding is needed, since the write completes before the next LOOKUP.

Decomposition:
- Package cpu64_l2_pkg holds:
  - op encodings (DIR_GET_S..DIR_EVICT);
  - FSM state enum (INIT, IDLE, LOOKUP, UPDATE, RESP);
  - entry struct {valid, sharers, owner_valid, owner_id, dirty}.
- Sub-module cpu64_l2_dir_next: purely combinational (op, core, old entry) → (new entry, probe, wb, err). It is unit-testable standalone; the FSM and counters live in the top.

Test Plan:
- Reset, SETS=8, WAYS=4 → dir_we_o high exactly 32 cycles, all-zero data, init_done_o=1 on cycle 33, req_ready_o=1 thereafter; reasserting rst mid-sweep restarts at set 0 way 0.
- GET_S core1 on invalid (set3, way2), then GET_S core2 → sharers=4'b0110, valid=1, probe=0, wb=0.
- From sharers=4'b0110, GET_M core3 → probe=4'b0110, wb=0; entry owner_valid=1, owner_id=3, sharers=0, dirty=0.
- MARK_DIRTY core3, then GET_S core0 → probe=4'b1000, wb=1; entry sharers=4'b1001, owner_valid=0, dirty=0.
- PUT_M core2 on a non-owned line, and op=7 → resp_err_o=1, dir_we_o never asserted, entry unchanged.
- resp_ready_i held low 5 cycles → resp fields stable, req_ready_o=0; EVICT of a dirty owned line → probe=owner bit, wb=1, entry zeroed.
